nbit_timer: RTL
===============

NBIT_TIMER -- requirements
Module: nbit_timer

Interface
REQ-001 Parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, count-step rate in Hz; DIV = CLK_HZ/TICK_HZ (integer, DIV >= 2, else elaboration error).
REQ-003 Parameter WIDTH, default 4, counter width in bits (1..32).
REQ-004 Parameter MAX_VAL, default 2**WIDTH-1, upper terminal value (1..2**WIDTH-1).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 en  input  1  run enable; level-sensitive.
REQ-008 dir  input  1  1 = count up, 0 = count down; sampled on each tick.
REQ-009 wrap  input  1  1 = wrap-around mode, 0 = one-shot mode; sampled on each tick.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value loaded on load; values > MAX_VAL load as MAX_VAL.
REQ-012 count  output  WIDTH  current counter value, registered.
REQ-013 tick  output  1  registered one-cycle pulse each time a step occurs.
REQ-014 wrapped  output  1  registered one-cycle pulse when count wraps.
REQ-015 done  output  1  registered level, high while in DONE state.

Function
REQ-016 FSM states: IDLE, RUN, DONE; no derived clocks, prescaler is a clock enable only.
REQ-017 Priority each cycle: rst_n low > load > en/FSM logic.
REQ-018 load: count <= min(load_val, MAX_VAL), prescaler <= 0, state <= IDLE, tick/wrapped <= 0, done <= 0.
REQ-019 IDLE: en=1 -> RUN next cycle; prescaler held at 0; count held.
REQ-020 RUN: en=0 -> IDLE next cycle, prescaler cleared, count held (pause).
REQ-021 RUN prescaler counts 0..DIV-1; the edge on which prescaler==DIV-1 is a step edge: prescaler <= 0, step applied, tick <= 1.
REQ-022 First step occurs exactly DIV cycles after the edge entering RUN; subsequent steps every DIV cycles while en stays 1.
REQ-023 Up step: count+1; at MAX_VAL with wrap=1 -> 0 and wrapped <= 1.
REQ-024 Down step: count-1; at 0 with wrap=1 -> MAX_VAL and wrapped <= 1.
REQ-025 One-shot (wrap=0): terminal is MAX_VAL (up) or 0 (down); if step result equals terminal, state <= DONE same edge.
REQ-026 One-shot with count already at terminal on a step edge: count unchanged, tick <= 1, state <= DONE.
REQ-027 DONE: count held, prescaler held at 0, done=1; en=0 -> IDLE (done clears); load per REQ-018; en=1 stays DONE.
REQ-028 tick and wrapped are 0 on every non-step edge; never high outside RUN->step edges.
REQ-029 dir or wrap changes take effect at the next step edge only; no glitch or extra step.
REQ-030 Arithmetic is WIDTH bits, never exceeds MAX_VAL; prescaler width ceil(log2(DIV)).

Reset
REQ-031 rst_n=0 at a clock edge: count=0, prescaler=0, state=IDLE, tick=0, wrapped=0, done=0, regardless of state or load.
REQ-032 Reset asserted mid-count aborts the step in progress; after release, first step is DIV cycles after RUN entry.

Verification (CLK_HZ=8, TICK_HZ=2 -> DIV=4, WIDTH=4, MAX_VAL=15 unless noted)
REQ-033 Reset, en=1, dir=1, wrap=1 -> RUN after 1 cycle, tick every 4 cycles, count 0,1..15,0 with wrapped pulse at 15->0 only.
REQ-034 dir=0, wrap=1 from count=0 -> first step gives 15 with wrapped=1, then 14, 13.
REQ-035 MAX_VAL=9, load_val=12 -> count=9; en=1, dir=1, wrap=0 -> next step: count stays 9, tick=1, done=1, no further changes.
REQ-036 One-shot down from load_val=3 -> 2,1,0 then DONE; en=0 -> done=0 next cycle, count stays 0.
REQ-037 en dropped for 10 cycles at prescaler=2 -> count frozen; re-enable -> next step 4 cycles after RUN re-entry.
REQ-038 load and rst_n=0 same edge -> reset wins (count=0); load and step same edge -> load wins, no tick.

Source files
------------

// File: rtl/nbit_timer_if.sv
// nbit_timer_if -- control/status bundle for nbit_timer.
//   master: drives en, dir, wrap, load, load_val; observes count, tick, wrapped, done
//   slave : the timer side (inverse directions)
//   WIDTH : width of load_val and count
interface nbit_timer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             en;
  logic             dir;
  logic             wrap;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             wrapped;
  logic             done;

  modport master (
    output en, dir, wrap, load, load_val,
    input  count, tick, wrapped, done
  );

  modport slave (
    input  en, dir, wrap, load, load_val,
    output count, tick, wrapped, done
  );
endinterface

// File: rtl/nbit_timer.sv
// nbit_timer -- prescaled up/down counter with wrap-around and one-shot modes.
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   bus (slave)  : en       run enable (level)
//                  dir      1 = up, 0 = down (sampled on step edges)
//                  wrap     1 = wrap-around, 0 = one-shot (sampled on step edges)
//                  load     synchronous load strobe, overrides counting
//                  load_val load value, clamped to MAX_VAL
//                  count    registered counter value
//                  tick     one-cycle pulse on every step edge
//                  wrapped  one-cycle pulse when the count rolls over
//                  done     high while the one-shot has finished
// The prescaler is a clock enable only: count advances once every DIV clocks
// while running, the first step landing DIV clocks after entering RUN.
module nbit_timer #(
  parameter int unsigned     CLK_HZ  = 12000000,
  parameter int unsigned     TICK_HZ = 1,
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  nbit_timer_if.slave   bus
);

  localparam int unsigned      DIV        = CLK_HZ / TICK_HZ;
  localparam int unsigned      PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);

  // Elaboration-time parameter sanity.
  if (DIV < 2) begin : g_bad_div
    $error("nbit_timer: CLK_HZ/TICK_HZ must be >= 2");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("nbit_timer: WIDTH must be 1..32");
  end
  if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("nbit_timer: MAX_VAL must be 1..2**WIDTH-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrapped_q, wrapped_d;
  logic             done_q, done_d;

  // Direction-dependent step helpers.
  logic [WIDTH-1:0] term_val;     // one-shot terminal value
  logic [WIDTH-1:0] roll_val;     // value after rolling over the terminal
  logic [WIDTH-1:0] stepped_val;  // plain +1 / -1 result
  logic [WIDTH-1:0] load_clamped;
  logic             at_term;

  always_comb begin
    term_val     = bus.dir ? MAX_V : '0;
    roll_val     = bus.dir ? '0 : MAX_V;
    stepped_val  = bus.dir ? (count_q + 1'b1) : (count_q - 1'b1);
    at_term      = (count_q == term_val);
    load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    wrapped_d = 1'b0;

    if (bus.load) begin
      count_d = load_clamped;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (bus.en) state_d = RUN;
        end
        RUN: begin
          if (!bus.en) begin
            // Pause: partial prescaler progress is discarded.
            state_d = IDLE;
            presc_d = '0;
          end else if (presc_q != PRESC_LAST) begin
            presc_d = presc_q + 1'b1;
          end else begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (at_term) begin
              if (bus.wrap) begin
                count_d   = roll_val;
                wrapped_d = 1'b1;
              end else begin
                // One-shot already sitting on its terminal: hold and finish.
                state_d = DONE;
              end
            end else begin
              count_d = stepped_val;
              if (!bus.wrap && stepped_val == term_val) state_d = DONE;
            end
          end
        end
        DONE: begin
          presc_d = '0;
          if (!bus.en) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.wrapped = wrapped_q;
  assign bus.done    = done_q;

endmodule
